// File: rtl/bcd_time_counter.sv
// bcd_time_counter: HH:MM:SS BCD time counter with prescaler, 12/24h display and validated load
module bcd_time_counter #(
  parameter int TICK_DIV = 1000,
  parameter int PRE_W = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       mode_12h,
  input  logic       load,
  input  logic [3:0] u_sec_in,
  input  logic [2:0] z_sec_in,
  input  logic [3:0] u_min_in,
  input  logic [2:0] z_min_in,
  input  logic [3:0] u_hour_in,
  input  logic [1:0] z_hour_in,
  output logic [3:0] u_sec_out,
  output logic [2:0] z_sec_out,
  output logic [3:0] u_min_out,
  output logic [2:0] z_min_out,
  output logic [3:0] u_hour_out,
  output logic [1:0] z_hour_out,
  output logic       pm_out,
  output logic       sec_pulse,
  output logic       day_wrap,
  output logic       load_err
);
  logic [PRE_W-1:0] pre;
  logic [3:0] u_sec, u_min, u_hour;
  logic [2:0] z_sec, z_min;
  logic [1:0] z_hour;
  logic tick, load_ok, c_min, c_hour, h_end, h_u9, wrap, midnight, noon;
  logic [3:0] n_u_sec, n_u_min, n_u_hour;
  logic [2:0] n_z_sec, n_z_min;
  logic [1:0] n_z_hour;

  assign tick = run && pre == PRE_W'(TICK_DIV - 1);
  assign load_ok = u_sec_in <= 4'd9 && z_sec_in <= 3'd5 && u_min_in <= 4'd9 && z_min_in <= 3'd5 &&
                   u_hour_in <= 4'd9 && (z_hour_in < 2'd2 || (z_hour_in == 2'd2 && u_hour_in <= 4'd3));

  // Next-second carry chain; the hour rolls 23 -> 00 rather than at 9 when the tens digit is 2
  always_comb begin
    c_min = u_sec == 4'd9 && z_sec == 3'd5;
    c_hour = c_min && u_min == 4'd9 && z_min == 3'd5;
    h_end = z_hour == 2'd2 && u_hour == 4'd3;
    h_u9 = u_hour == 4'd9;
    wrap = c_hour && h_end;
    n_u_sec = u_sec == 4'd9 ? 4'd0 : u_sec + 4'd1;
    n_z_sec = u_sec != 4'd9 ? z_sec : z_sec == 3'd5 ? 3'd0 : z_sec + 3'd1;
    n_u_min = !c_min ? u_min : u_min == 4'd9 ? 4'd0 : u_min + 4'd1;
    n_z_min = !(c_min && u_min == 4'd9) ? z_min : z_min == 3'd5 ? 3'd0 : z_min + 3'd1;
    n_u_hour = !c_hour ? u_hour : (h_end || h_u9) ? 4'd0 : u_hour + 4'd1;
    n_z_hour = !c_hour ? z_hour : h_end ? 2'd0 : h_u9 ? z_hour + 2'd1 : z_hour;
  end

  // 12h display decode of the 24h state: 00 -> 12 am, 13-23 -> 01-11 pm
  always_comb begin
    pm_out = z_hour == 2'd2 || (z_hour == 2'd1 && u_hour >= 4'd2);
    midnight = z_hour == 2'd0 && u_hour == 4'd0;
    noon = z_hour == 2'd1 && u_hour == 4'd2;
    u_hour_out = !mode_12h ? u_hour : (midnight || noon) ? 4'd2 : !pm_out ? u_hour :
                 (z_hour == 2'd2 && u_hour < 4'd2) ? u_hour + 4'd8 : u_hour - 4'd2;
    z_hour_out = !mode_12h ? z_hour : (midnight || noon) ? 2'd1 : !pm_out ? z_hour :
                 (z_hour == 2'd2 && u_hour >= 4'd2) ? 2'd1 : 2'd0;
  end

  assign u_sec_out = u_sec;
  assign z_sec_out = z_sec;
  assign u_min_out = u_min;
  assign z_min_out = z_min;

  // Prescaler, time state and pulses; a valid load overrides a coincident tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre <= '0;
      {z_hour, u_hour, z_min, u_min, z_sec, u_sec} <= '0;
      sec_pulse <= 1'b0;
      day_wrap <= 1'b0;
      load_err <= 1'b0;
    end else begin
      sec_pulse <= 1'b0;
      day_wrap <= 1'b0;
      load_err <= load && !load_ok;
      if (load && load_ok) begin
        pre <= '0;
        {z_hour, u_hour, z_min, u_min, z_sec, u_sec} <=
          {z_hour_in, u_hour_in, z_min_in, u_min_in, z_sec_in, u_sec_in};
      end else begin
        if (run) pre <= tick ? '0 : pre + 1'b1;
        if (tick) begin
          {z_hour, u_hour, z_min, u_min, z_sec, u_sec} <=
            {n_z_hour, n_u_hour, n_z_min, n_u_min, n_z_sec, n_u_sec};
          sec_pulse <= 1'b1;
          day_wrap <= wrap;
        end
      end
    end
  end
endmodule
